// File: rtl/pin_test_pkg.sv
// Shared types and constants for the pin-test harness.
package pin_test_pkg;
    typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

    // Fibonacci taps 16,14,13,11 of a right-shifting register map to bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS  = 16'h002D;
    localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;
endpackage

// File: rtl/pin_test_if.sv
// Pin-level bundle between the harness and the board-side design under test.
interface pin_test_if #(parameter int ERR_W = 8) ();
    // i_Start is a one-cycle request, taken only in IDLE or DONE; i_Vectors is sampled
    // in that same cycle. The result fields are stable for as long as o_Done is high.
    logic                 i_Start;
    logic [15:0]          i_Vectors;
    logic                 o_Drive1;
    logic                 o_Drive2;
    logic [4:0]           i_Sense;
    logic                 o_Busy;
    logic                 o_Done;
    logic                 o_Pass;
    logic [ERR_W-1:0]     o_ErrCount;
    logic [15:0]          o_FirstErrIdx;
    logic [4:0]           o_FirstErrBits;
    pin_test_pkg::state_t dbg_state;

    modport master (
        input  i_Start, i_Vectors, i_Sense,
        output o_Drive1, o_Drive2, o_Busy, o_Done, o_Pass,
               o_ErrCount, o_FirstErrIdx, o_FirstErrBits, dbg_state
    );

    modport slave (
        output i_Start, i_Vectors, i_Sense,
        input  o_Drive1, o_Drive2, o_Busy, o_Done, o_Pass,
               o_ErrCount, o_FirstErrIdx, o_FirstErrBits, dbg_state
    );
endinterface

// File: rtl/pin_test_lfsr.sv
// 16-bit Fibonacci LFSR with seed reload and advance enables; exposes the two drive bits.
module pin_test_lfsr
    import pin_test_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       adv,
    output logic [1:0] pair
);
    logic [15:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (adv) begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

    assign pair = q[1:0];
endmodule

// File: rtl/pin_test_harness.sv
// Drives the pin-test design from an LFSR, compares its returned outputs against a
// delayed model of the expected response, and reports count and first failure.
module pin_test_harness
    import pin_test_pkg::*;
#(
    parameter int          SYNC_STAGES = 1,
    parameter int          ERR_W       = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic        i_Clock,
    input logic        i_Reset_n,
    pin_test_if.master bus
);
    localparam int               HD      = SYNC_STAGES + 2;
    localparam int               D2W     = SYNC_STAGES + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state, state_nx;
    logic             accept;
    logic [1:0]       lfsr_pair;
    logic [1:0]       drive;
    logic [15:0]      remaining;
    logic [15:0]      cmp_idx;
    logic [HD-1:0]    hist_v;
    logic [HD-1:0]    hist_d1;
    logic [D2W-1:0]   hist_d2;
    logic [4:0]       sample;
    logic [4:0]       expect_v;
    logic [4:0]       care;
    logic [4:0]       mask;
    logic             cmp_en;
    logic             pending;
    logic             prev_d1;
    logic             cur_d2;
    logic [ERR_W-1:0] err_cnt;
    logic [15:0]      first_idx;
    logic [4:0]       first_bits;

    pin_test_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (i_Clock),
        .rst_n (i_Reset_n),
        .load  (state == PRIME),
        .adv   (state == RUN),
        .pair  (lfsr_pair)
    );

    // Returned outputs pass through SYNC_STAGES flops; the history below is deepened to match.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sample = bus.i_Sense;
        end else begin : g_sync
            logic [4:0] sync_q [SYNC_STAGES];
            always_ff @(posedge i_Clock or negedge i_Reset_n) begin
                if (!i_Reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= bus.i_Sense;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign sample = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.i_Start) begin
                    accept   = 1'b1;
                    state_nx = (bus.i_Vectors == 16'd0) ? DONE : PRIME;
                end
            end
            PRIME:   state_nx = RUN;
            RUN:     if (remaining == 16'd1) state_nx = DRAIN;
            DRAIN:   if (!pending) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // hist[SYNC_STAGES] is the vector being compared now; the entry after it is its predecessor.
    assign cmp_en   = hist_v[SYNC_STAGES];
    assign pending  = |hist_v[SYNC_STAGES:0];
    assign prev_d1  = hist_d1[SYNC_STAGES+1];
    assign cur_d2   = hist_d2[SYNC_STAGES];
    assign expect_v = {~cur_d2 & ~prev_d1, ~cur_d2, cur_d2, ~prev_d1, prev_d1};
    assign care     = hist_v[SYNC_STAGES+1] ? 5'b11111 : 5'b01100;
    assign mask     = (sample ^ expect_v) & care;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            hist_v  <= '0;
            hist_d1 <= '0;
            hist_d2 <= '0;
        end else if (state == PRIME) begin
            hist_v  <= '0;
            hist_d1 <= '0;
            hist_d2 <= '0;
        end else begin
            hist_v  <= (hist_v << 1) | HD'(state == RUN);
            hist_d1 <= (hist_d1 << 1) | HD'(lfsr_pair[0]);
            hist_d2 <= (hist_d2 << 1) | D2W'(lfsr_pair[1]);
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= IDLE;
            drive      <= '0;
            remaining  <= '0;
            cmp_idx    <= '0;
            err_cnt    <= '0;
            first_idx  <= NO_ERR_IDX;
            first_bits <= '0;
        end else begin
            state <= state_nx;
            if (accept) remaining <= bus.i_Vectors;
            if (accept || state == PRIME) begin
                cmp_idx    <= '0;
                err_cnt    <= '0;
                first_idx  <= NO_ERR_IDX;
                first_bits <= '0;
            end else if (cmp_en) begin
                cmp_idx <= cmp_idx + 16'd1;
                if (mask != 5'd0) begin
                    if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
                    if (err_cnt == '0) begin
                        first_idx  <= cmp_idx;
                        first_bits <= mask;
                    end
                end
            end
            if (state == RUN) begin
                drive     <= lfsr_pair;
                remaining <= remaining - 16'd1;
            end
        end
    end

    assign bus.o_Drive1       = drive[0];
    assign bus.o_Drive2       = drive[1];
    assign bus.o_Busy         = (state == PRIME) || (state == RUN) || (state == DRAIN);
    assign bus.o_Done         = (state == DONE);
    assign bus.o_Pass         = (state == DONE) && (err_cnt == '0);
    assign bus.o_ErrCount     = err_cnt;
    assign bus.o_FirstErrIdx  = first_idx;
    assign bus.o_FirstErrBits = first_bits;
    assign bus.dbg_state      = state;
endmodule

// File: tb/tb_pin_test_harness.sv
// Three harness instances (SYNC_STAGES/ERR_W = 1/8, 0/4, 3/8), each wired to a behavioural
// pin-test design with selectable faults; results are scoreboarded on each o_Done rise.
module tb_pin_test_harness;
    import pin_test_pkg::*;

    typedef struct packed {
        logic [1:0]  inst;
        logic        pass;
        logic [7:0]  err;
        logic [15:0] idx;
        logic [4:0]  bits;
        logic [15:0] lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int start_cyc [3];

    logic              start_a [3];
    logic [15:0]       vec_a   [3];
    int                fault_a [3];
    logic [2:0]        d1_a, d2_a, busy_a, done_a, pass_a;
    logic [2:0][7:0]   err_a;
    logic [2:0][15:0]  idx_a;
    logic [2:0][4:0]   bits_a;
    logic [2:0][2:0]   st_a;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int SS = (g == 1) ? 0 : (g == 2) ? 3 : 1;
        localparam int EW = (g == 1) ? 4 : 8;
        pin_test_if #(.ERR_W(EW)) pif ();
        logic       r1 = 1'b0;
        logic [4:0] ideal;
        logic [4:0] sense;

        pin_test_harness #(.SYNC_STAGES(SS), .ERR_W(EW), .LFSR_SEED(16'hACE1)) dut (
            .i_Clock   (clk),
            .i_Reset_n (rst_n),
            .bus       (pif.master)
        );

        // Behavioural pin-test design: outputs 1/2 registered from input 1, 3/4 direct from input 2
        always @(posedge clk) r1 <= pif.o_Drive1;
        always_comb begin
            ideal = {~pif.o_Drive2 & ~r1, ~pif.o_Drive2, pif.o_Drive2, ~r1, r1};
            sense = ideal;
            case (fault_a[g])
                1:       sense[1]   = 1'b0;
                2:       sense[2]   = ~ideal[2];
                3:       sense[1:0] = ~ideal[1:0];
                default: ;
            endcase
        end

        assign pif.i_Sense   = sense;
        assign pif.i_Start   = start_a[g];
        assign pif.i_Vectors = vec_a[g];
        assign d1_a[g]   = pif.o_Drive1;
        assign d2_a[g]   = pif.o_Drive2;
        assign busy_a[g] = pif.o_Busy;
        assign done_a[g] = pif.o_Done;
        assign pass_a[g] = pif.o_Pass;
        assign err_a[g]  = 8'(pif.o_ErrCount);
        assign idx_a[g]  = pif.o_FirstErrIdx;
        assign bits_a[g] = pif.o_FirstErrBits;
        assign st_a[g]   = pif.dbg_state;
    end

    function automatic int ss_of(input int i);
        return (i == 1) ? 0 : (i == 2) ? 3 : 1;
    endfunction

    function automatic int ew_of(input int i);
        return (i == 1) ? 4 : 8;
    endfunction

    function automatic logic [15:0] lfsr_after(input int steps);
        logic [15:0] q = 16'hACE1;
        for (int s = 0; s < steps; s++) q = {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
        return q;
    endfunction

    // Latency is counted in clock edges after the edge that accepts the start.
    function automatic exp_t model(input int inst, input int n, input int fault);
        exp_t        e;
        logic [15:0] q;
        logic        d1, d2, prev_d1;
        logic [4:0]  ideal, m;
        int          cnt, sat;
        q = 16'hACE1;
        prev_d1 = 1'b0;
        cnt = 0;
        e.inst = 2'(inst);
        e.idx  = 16'hFFFF;
        e.bits = 5'd0;
        for (int k = 0; k < n; k++) begin
            d1 = q[0];
            d2 = q[1];
            ideal = {~d2 & ~prev_d1, ~d2, d2, ~prev_d1, prev_d1};
            case (fault)
                1:       m = {3'b000, ideal[1], 1'b0};
                2:       m = 5'b00100;
                3:       m = 5'b00011;
                default: m = 5'b00000;
            endcase
            if (k == 0) m = m & 5'b01100;
            if (m != 5'd0) begin
                if (cnt == 0) begin
                    e.idx  = 16'(k);
                    e.bits = m;
                end
                cnt++;
            end
            prev_d1 = d1;
            q = {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
        end
        sat = (1 << ew_of(inst)) - 1;
        e.err  = 8'((cnt > sat) ? sat : cnt);
        e.pass = (cnt == 0);
        e.lat  = 16'((n == 0) ? 0 : n + ss_of(inst) + 3);
        return e;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, inst, act, req);
        end
    endtask

    task automatic check_reset(input int i);
        check("rst_drive1", i, 32'(d1_a[i]), 32'd0);
        check("rst_drive2", i, 32'(d2_a[i]), 32'd0);
        check("rst_busy", i, 32'(busy_a[i]), 32'd0);
        check("rst_done", i, 32'(done_a[i]), 32'd0);
        check("rst_pass", i, 32'(pass_a[i]), 32'd0);
        check("rst_err", i, 32'(err_a[i]), 32'd0);
        check("rst_idx", i, 32'(idx_a[i]), 32'hFFFF);
        check("rst_bits", i, 32'(bits_a[i]), 32'd0);
        check("rst_state", i, 32'(st_a[i]), 32'(IDLE));
    endtask

    task automatic start_run(input int i, input int n, input int fault, input bit expect_it);
        @(negedge clk);
        fault_a[i] = fault;
        vec_a[i]   = 16'(n);
        start_a[i] = 1'b1;
        if (expect_it) exp_q.push_back(model(i, n, fault));
        @(posedge clk);
        #1;
        start_cyc[i] = cyc;
        start_a[i]   = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout pending=%0d", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [2:0] done_prev = '0;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_a[i] && !done_prev[i]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done inst=%0d", i);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_inst", i, 32'(i), 32'(mon_e.inst));
                    check("pass", i, 32'(pass_a[i]), 32'(mon_e.pass));
                    check("err_count", i, 32'(err_a[i]), 32'(mon_e.err));
                    check("first_idx", i, 32'(idx_a[i]), 32'(mon_e.idx));
                    check("first_bits", i, 32'(bits_a[i]), 32'(mon_e.bits));
                    check("latency", i, 32'(cyc - start_cyc[i]), 32'(mon_e.lat));
                end
            end
        end
        done_prev = done_a;
    end

    logic [15:0] last_q;

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            vec_a[i]   = 16'd0;
            fault_a[i] = 0;
            start_cyc[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length run from IDLE: done next edge, drives untouched
        start_run(2, 0, 0, 1);
        wait_drain(50);
        check("n0_idle_drive1", 2, 32'(d1_a[2]), 32'd0);
        check("n0_idle_drive2", 2, 32'(d2_a[2]), 32'd0);

        start_run(0, 100, 0, 1);
        wait_drain(400);
        start_run(0, 100, 1, 1);
        wait_drain(400);

        // Zero-length run from DONE after a failing run
        last_q = lfsr_after(99);
        start_run(0, 0, 0, 0);
        @(negedge clk);
        check("n0_done_done", 0, 32'(done_a[0]), 32'd1);
        check("n0_done_pass", 0, 32'(pass_a[0]), 32'd1);
        check("n0_done_err", 0, 32'(err_a[0]), 32'd0);
        check("n0_done_idx", 0, 32'(idx_a[0]), 32'hFFFF);
        check("n0_done_drive1", 0, 32'(d1_a[0]), 32'(last_q[0]));
        check("n0_done_drive2", 0, 32'(d2_a[0]), 32'(last_q[1]));

        start_run(1, 50, 2, 1);
        wait_drain(400);
        start_run(1, 100, 0, 1);
        wait_drain(400);
        start_run(2, 100, 0, 1);
        wait_drain(400);
        start_run(2, 100, 3, 1);
        wait_drain(400);
        start_run(2, 1, 0, 1);
        wait_drain(50);

        // One-cycle reset in the middle of a run
        start_run(0, 100, 0, 0);
        repeat (30) @(negedge clk);
        check("mid_busy", 0, 32'(busy_a[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset(0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 0, 32'(busy_a[0]), 32'd0);
        check("post_rst_state", 0, 32'(st_a[0]), 32'(IDLE));

        // Clean rerun with a stray start pulse while running
        start_run(0, 100, 0, 1);
        repeat (20) @(negedge clk);
        vec_a[0]   = 16'd5;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        wait_drain(400);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
